// File: rtl/fifo_pkg.sv
// Shared FIFO controller definitions: default address width, depth derivation
// and the per-cycle operation classification.
package fifo_pkg;

    localparam int unsigned FIFO_ADDR_WIDTH = 2;

    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    // Bit 1 = accepted write, bit 0 = accepted read.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer/occupancy controller for a circular FIFO; the storage array lives
// beside it and is addressed through w_addr, r_addr and mem_wr_en.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  clr_err,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_AF   = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH-1:0] head, tail, head_nxt, tail_nxt;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  full_nxt, empty_nxt;
    logic                  overflow_nxt, underflow_nxt;
    logic                  wr_ok, rd_ok;
    fifo_op_e              op;

    // A read frees a slot in the same cycle, so a full FIFO still takes a write.
    assign wr_ok = wr & (~full | rd);
    assign rd_ok = rd & ~empty;
    assign op    = fifo_op_e'({wr_ok, rd_ok});

    always_comb begin
        head_nxt  = head;
        tail_nxt  = tail;
        count_nxt = count;
        full_nxt  = full;
        empty_nxt = empty;
        unique case (op)
            OP_PUSH: begin
                tail_nxt  = tail + 1'b1;
                count_nxt = count + 1'b1;
                empty_nxt = 1'b0;
                full_nxt  = (count_nxt == CNT_FULL);
            end
            OP_POP: begin
                head_nxt  = head + 1'b1;
                count_nxt = count - 1'b1;
                full_nxt  = 1'b0;
                empty_nxt = (count_nxt == '0);
            end
            OP_BOTH: begin
                head_nxt = head + 1'b1;
                tail_nxt = tail + 1'b1;
            end
            default: ;
        endcase
    end

    // A fresh error outranks clr_err in the same cycle.
    always_comb begin
        overflow_nxt  = overflow;
        underflow_nxt = underflow;
        if (wr & full & ~rd)
            overflow_nxt = 1'b1;
        else if (clr_err)
            overflow_nxt = 1'b0;
        if (rd & empty)
            underflow_nxt = 1'b1;
        else if (clr_err)
            underflow_nxt = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            head      <= head_nxt;
            tail      <= tail_nxt;
            count     <= count_nxt;
            full      <= full_nxt;
            empty     <= empty_nxt;
            overflow  <= overflow_nxt;
            underflow <= underflow_nxt;
        end
    end

    assign mem_wr_en    = wr_ok;
    assign w_addr       = tail;
    assign r_addr       = head;
    assign almost_full  = (count >= CNT_AF);
    assign almost_empty = (count <= CNT_ONE);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: queue-based occupancy model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_fifo_ctrl;

    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
    logic          mem_wr_en, full, empty, almost_full, almost_empty;
    logic          overflow, underflow;
    logic [AW-1:0] w_addr, r_addr;
    logic [AW:0]   count;

    int n_tests = 0;
    int n_fail  = 0;

    logic          pre_we;
    logic [AW-1:0] pre_w, pre_r;

    fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .rd           (rd),
        .clr_err      (clr_err),
        .mem_wr_en    (mem_wr_en),
        .w_addr       (w_addr),
        .r_addr       (r_addr),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of the addresses currently occupied, oldest first.
    int q[$];
    int m_tail = 0;
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;

    always @(posedge clk or posedge reset) begin
        bit wa, ra;
        if (reset) begin
            q.delete();
            m_tail = 0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            wa = wr && (q.size() < DEPTH || rd);
            ra = rd && q.size() > 0;
            if (wr && q.size() == DEPTH && !rd) m_ovf = 1'b1;
            else if (clr_err)                   m_ovf = 1'b0;
            if (rd && q.size() == 0)            m_udf = 1'b1;
            else if (clr_err)                   m_udf = 1'b0;
            if (ra) void'(q.pop_front());
            if (wa) begin
                q.push_back(m_tail);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
    end

    always @(negedge clk) begin
        int c;
        c = q.size();
        chk("count",        32'(count),        c);
        chk("full",         32'(full),         32'(c == DEPTH));
        chk("empty",        32'(empty),        32'(c == 0));
        chk("almost_full",  32'(almost_full),  32'(c >= DEPTH - 1));
        chk("almost_empty", 32'(almost_empty), 32'(c <= 1));
        chk("w_addr",       32'(w_addr),       m_tail);
        chk("r_addr",       32'(r_addr),       (c > 0) ? q[0] : m_tail);
        chk("mem_wr_en",    32'(mem_wr_en),    32'(wr && (c < DEPTH || rd)));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_udf));
    end

    // Entered 1 time unit after a rising edge; returns 1 unit after the next one.
    task automatic cyc(input logic w, input logic r, input logic c);
        wr = w; rd = r; clr_err = c;
        #1;
        pre_we = mem_wr_en;
        pre_w  = w_addr;
        pre_r  = r_addr;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count",  32'(count), 0);
        chk("rst_empty",  32'(empty), 1);
        chk("rst_full",   32'(full), 0);
        chk("rst_ae",     32'(almost_empty), 1);
        chk("rst_af",     32'(almost_full), 0);
        chk("rst_we",     32'(mem_wr_en), 0);
        reset = 1'b0;

        // Fill: addresses 0..3, then tail wraps to 0
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk("fill_waddr", 32'(pre_w), i);
            chk("fill_we",    32'(pre_we), 1);
            if (i == 1) chk("af_at2", 32'(almost_full), 0);
            if (i == 2) chk("af_at3", 32'(almost_full), 1);
        end
        chk("fill_count", 32'(count), 4);
        chk("fill_full",  32'(full), 1);
        chk("fill_wrap",  32'(w_addr), 0);

        // Overflow on full with no read, then clear
        cyc(1'b1, 1'b0, 1'b0);
        chk("ovf_we",    32'(pre_we), 0);
        chk("ovf_count", 32'(count), 4);
        chk("ovf_waddr", 32'(w_addr), 0);
        chk("ovf_raddr", 32'(r_addr), 0);
        chk("ovf_flag",  32'(overflow), 1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("ovf_clr",   32'(overflow), 0);

        // Drain: addresses 0..3
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            chk("drain_raddr", 32'(pre_r), i);
            if (i == 1) chk("ae_at2", 32'(almost_empty), 0);
            if (i == 2) chk("ae_at1", 32'(almost_empty), 1);
        end
        chk("drain_empty", 32'(empty), 1);
        chk("drain_wrap",  32'(r_addr), 0);
        chk("drain_udf",   32'(underflow), 0);

        // Empty with simultaneous wr/rd: write wins, read flagged
        cyc(1'b1, 1'b1, 1'b0);
        chk("ewr_we",    32'(pre_we), 1);
        chk("ewr_count", 32'(count), 1);
        chk("ewr_empty", 32'(empty), 0);
        chk("ewr_udf",   32'(underflow), 1);
        chk("ewr_waddr", 32'(w_addr), 1);
        chk("ewr_raddr", 32'(r_addr), 0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("udf_clr",   32'(underflow), 0);

        // Full with simultaneous wr/rd: both pointers advance
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        chk("refill_count", 32'(count), 4);
        cyc(1'b1, 1'b1, 1'b0);
        chk("fwr_we",    32'(pre_we), 1);
        chk("fwr_waddr", 32'(w_addr), 1);
        chk("fwr_raddr", 32'(r_addr), 1);
        chk("fwr_count", 32'(count), 4);
        chk("fwr_full",  32'(full), 1);
        chk("fwr_ovf",   32'(overflow), 0);

        // Count 2 streaming: head 3->1, tail 1->3 across the wrap
        repeat (2) cyc(1'b0, 1'b1, 1'b0);
        chk("s_start_count", 32'(count), 2);
        chk("s_start_raddr", 32'(r_addr), 3);
        repeat (6) cyc(1'b1, 1'b1, 1'b0);
        chk("s_count", 32'(count), 2);
        chk("s_raddr", 32'(r_addr), 1);
        chk("s_waddr", 32'(w_addr), 3);
        chk("s_ovf",   32'(overflow), 0);
        chk("s_udf",   32'(underflow), 0);

        // Asynchronous reset at count 3
        cyc(1'b1, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 3);
        #2 reset = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_full",  32'(full), 0);
        chk("arst_waddr", 32'(w_addr), 0);
        chk("arst_raddr", 32'(r_addr), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        chk("post_rst_waddr", 32'(pre_w), 0);
        chk("post_rst_we",    32'(pre_we), 1);
        chk("post_rst_count", 32'(count), 1);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
